// File: rtl/multififo_v2_pkg.sv
// Shared width helpers and run-length/mask functions for the multi-port FIFO.
// Lane vectors are zero-extended to MAX_LANES before being handed to the helpers.
package multififo_v2_pkg;

   localparam int MAX_LANES = 64;

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Length of the unbroken run of ones starting at bit 0.
   function automatic int prefix_ones(input logic [MAX_LANES-1:0] vec);
      int  n;
      logic run;
      n   = 0;
      run = 1'b1;
      for (int i = 0; i < MAX_LANES; i++) begin
         run = run & vec[i];
         if (run) n++;
      end
      return n;
   endfunction

   // Thermometer mask with the low n bits set.
   function automatic logic [MAX_LANES-1:0] expand_ones(input int n);
      logic [MAX_LANES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/multififo_v2_if.sv
// Enqueue/dequeue bundle of the multi-port FIFO; master drives requests,
// slave (the FIFO) returns admission, head entries and occupancy.
interface multififo_v2_if #(
   parameter int IN_PORT_NUM  = 4,
   parameter int OUT_PORT_NUM = 4,
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 16
) ();

   localparam int PTR_W = multififo_v2_pkg::ptr_width(DEPTH);

   logic [IN_PORT_NUM-1:0]  data_in_enable;
   logic [WIDTH-1:0]        data_in [IN_PORT_NUM];
   logic [IN_PORT_NUM-1:0]  data_in_valid;
   logic                    push;
   logic                    full;
   logic                    flush;
   logic [WIDTH-1:0]        data_out [OUT_PORT_NUM];
   logic [OUT_PORT_NUM-1:0] data_out_valid;
   logic [OUT_PORT_NUM-1:0] data_pop_valid;
   logic                    pop;
   logic                    empty;
   logic [PTR_W-1:0]        used_count;
   logic [PTR_W-1:0]        free_count;
   logic                    almost_full;

   modport master (
      input  data_in_enable, full, data_out, data_out_valid, empty,
             used_count, free_count, almost_full,
      output data_in, data_in_valid, push, flush, data_pop_valid, pop
   );

   modport slave (
      output data_in_enable, full, data_out, data_out_valid, empty,
             used_count, free_count, almost_full,
      input  data_in, data_in_valid, push, flush, data_pop_valid, pop
   );

endinterface

// File: rtl/multififo_v2_rotator.sv
// Barrel rotate over a power-of-two ring: dout[j] = din[(j + shift) mod N].
// Used for both the write lane-to-bank mapping and the head read-out.
module multififo_v2_rotator #(
   parameter int N     = 8,
   parameter int OUT_N = 8,
   parameter int WIDTH = 32
) (
   input  logic [$clog2(N)-1:0] shift,
   input  logic [WIDTH-1:0]     din  [N],
   output logic [WIDTH-1:0]     dout [OUT_N]
);

   localparam int SH_W = $clog2(N);

   always_comb begin
      for (int j = 0; j < OUT_N; j++) begin
         dout[j] = din[SH_W'(j) + shift];
      end
   end

endmodule

// File: rtl/multififo_v2.sv
// Multi-port in / multi-port out FIFO with occupancy and almost-full outputs.
// Head entries are read combinationally; pointers carry one extra wrap bit.
module multififo_v2
   import multififo_v2_pkg::*;
#(
   parameter int IN_PORT_NUM        = 4,
   parameter int OUT_PORT_NUM       = 4,
   parameter int WIDTH              = 32,
   parameter int DEPTH              = 16,
   parameter int ALMOST_FULL_THRESH = DEPTH - IN_PORT_NUM
) (
   input logic           clk,
   input logic           rst,
   multififo_v2_if.slave bus
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int AW    = addr_width(DEPTH);

   logic [PTR_W-1:0]        rptr, wptr;
   logic [PTR_W-1:0]        used_cnt, free_cnt;
   logic [PTR_W-1:0]        in_num, out_num;
   logic [IN_PORT_NUM-1:0]  in_en, in_mask;
   logic [OUT_PORT_NUM-1:0] out_vld, out_mask;
   logic [DEPTH-1:0]        wr_sel;
   logic [AW-1:0]           wr_shift;
   logic [WIDTH-1:0]        mem     [DEPTH];
   logic [WIDTH-1:0]        wr_lane [DEPTH];
   logic [WIDTH-1:0]        wr_rot  [DEPTH];
   logic [WIDTH-1:0]        rd_rot  [OUT_PORT_NUM];

   assign used_cnt = wptr - rptr;
   assign free_cnt = PTR_W'(DEPTH) - used_cnt;

   // Admission and visibility both come from the registered pointers only.
   assign in_en    = IN_PORT_NUM'(expand_ones(int'(free_cnt)));
   assign out_vld  = OUT_PORT_NUM'(expand_ones(int'(used_cnt)));
   assign in_mask  = bus.data_in_valid & in_en;
   assign out_mask = out_vld & bus.data_pop_valid;
   assign in_num   = PTR_W'(prefix_ones(MAX_LANES'(in_mask)));
   assign out_num  = PTR_W'(prefix_ones(MAX_LANES'(out_mask)));

   for (genvar b = 0; b < DEPTH; b++) begin : g_lane
      if (b < IN_PORT_NUM) begin : g_port
         assign wr_lane[b] = bus.data_in[b];
      end else begin : g_pad
         assign wr_lane[b] = '0;
      end
   end

   assign wr_shift = -wptr[AW-1:0];

   multififo_v2_rotator #(.N(DEPTH), .OUT_N(DEPTH), .WIDTH(WIDTH)) u_wr_rot (
      .shift (wr_shift),
      .din   (wr_lane),
      .dout  (wr_rot)
   );

   multififo_v2_rotator #(.N(DEPTH), .OUT_N(OUT_PORT_NUM), .WIDTH(WIDTH)) u_rd_rot (
      .shift (rptr[AW-1:0]),
      .din   (mem),
      .dout  (rd_rot)
   );

   // Bank b receives lane (b - wptr) mod DEPTH when that lane is admitted.
   always_comb begin
      logic [AW-1:0] off;
      off    = '0;
      wr_sel = '0;
      for (int b = 0; b < DEPTH; b++) begin
         off       = AW'(b) - wptr[AW-1:0];
         wr_sel[b] = ({1'b0, off} < in_num);
      end
   end

   always_ff @(posedge clk) begin
      if (bus.push) begin
         for (int b = 0; b < DEPTH; b++) begin
            if (wr_sel[b]) mem[b] <= wr_rot[b];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || bus.flush) begin
         rptr <= '0;
         wptr <= '0;
      end else begin
         if (bus.push) wptr <= wptr + in_num;
         if (bus.pop)  rptr <= rptr + out_num;
      end
   end

   for (genvar i = 0; i < OUT_PORT_NUM; i++) begin : g_out
      assign bus.data_out[i] = rd_rot[i];
   end

   assign bus.data_in_enable = in_en;
   assign bus.data_out_valid = out_vld;
   assign bus.used_count     = used_cnt;
   assign bus.free_count     = free_cnt;
   assign bus.empty          = (used_cnt == '0);
   assign bus.full           = (used_cnt == PTR_W'(DEPTH));
   assign bus.almost_full    = (used_cnt >= PTR_W'(ALMOST_FULL_THRESH));

endmodule

// File: tb/tb_multififo_v2.sv
// Directed bench for multififo_v2 (IN=4, OUT=4, WIDTH=8, DEPTH=8, THRESH=4).
module tb_multififo_v2;

   localparam int IN_N = 4;
   localparam int OUT_N = 4;
   localparam int W = 8;
   localparam int D = 8;
   localparam int TH = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [7:0] q[$];
   logic [7:0] v;

   always #5 clk = ~clk;

   multififo_v2_if #(.IN_PORT_NUM(IN_N), .OUT_PORT_NUM(OUT_N), .WIDTH(W), .DEPTH(D)) bus ();

   multififo_v2 #(
      .IN_PORT_NUM(IN_N), .OUT_PORT_NUM(OUT_N), .WIDTH(W), .DEPTH(D),
      .ALMOST_FULL_THRESH(TH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] vld, input logic [7:0] base);
      for (int k = 0; k < IN_N; k++) bus.data_in[k] = base + 8'(k);
      bus.data_in_valid = vld;
   endtask

   task automatic idle();
      bus.push           = 1'b0;
      bus.pop            = 1'b0;
      bus.flush          = 1'b0;
      bus.data_in_valid  = '0;
      bus.data_pop_valid = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      idle();
      set_in(4'b0000, 8'h00);
      tick();
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_used", 32'(bus.used_count), 0);
      chk("rst_free", 32'(bus.free_count), 8);
      chk("rst_in_en", 32'(bus.data_in_enable), 32'hF);
      chk("rst_out_vld", 32'(bus.data_out_valid), 0);
      chk("rst_af", 32'(bus.almost_full), 0);
      rst = 1'b1;

      // Gapped push: only the leading run 0x10,0x11 is admitted.
      set_in(4'b1011, 8'h10); bus.push = 1'b1; tick(); idle();
      chk("gap_used", 32'(bus.used_count), 2);
      chk("gap_out_vld", 32'(bus.data_out_valid), 32'h3);
      chk("gap_d0", 32'(bus.data_out[0]), 32'h10);
      chk("gap_d1", 32'(bus.data_out[1]), 32'h11);
      chk("gap_in_en", 32'(bus.data_in_enable), 32'hF);

      // Fill limit.
      set_in(4'b1111, 8'h20); bus.push = 1'b1; tick(); idle();
      chk("fill6_used", 32'(bus.used_count), 6);
      chk("fill6_in_en", 32'(bus.data_in_enable), 32'h3);
      chk("fill6_af", 32'(bus.almost_full), 1);
      chk("fill6_d2", 32'(bus.data_out[2]), 32'h20);
      chk("fill6_d3", 32'(bus.data_out[3]), 32'h21);
      set_in(4'b1111, 8'h30); bus.push = 1'b1; tick(); idle();
      chk("fill8_used", 32'(bus.used_count), 8);
      chk("fill8_full", 32'(bus.full), 1);
      chk("fill8_in_en", 32'(bus.data_in_enable), 0);
      chk("fill8_af", 32'(bus.almost_full), 1);
      chk("fill8_free", 32'(bus.free_count), 0);
      set_in(4'b1111, 8'h40); bus.push = 1'b1; tick(); idle();
      chk("full_push_used", 32'(bus.used_count), 8);
      chk("full_push_d0", 32'(bus.data_out[0]), 32'h10);

      // Push+pop while full: pop 2, nothing written.
      set_in(4'b1111, 8'h50); bus.push = 1'b1; bus.pop = 1'b1; bus.data_pop_valid = 4'b0011;
      tick(); idle();
      chk("pp_used", 32'(bus.used_count), 6);
      chk("pp_full", 32'(bus.full), 0);
      chk("pp_d0", 32'(bus.data_out[0]), 32'h20);
      chk("pp_in_en", 32'(bus.data_in_enable), 32'h3);
      set_in(4'b1111, 8'h60); bus.push = 1'b1; tick(); idle();
      chk("refill_used", 32'(bus.used_count), 8);
      chk("refill_d0", 32'(bus.data_out[0]), 32'h20);
      bus.pop = 1'b1; bus.data_pop_valid = 4'b1111; tick(); idle();
      chk("pop4_used", 32'(bus.used_count), 4);
      chk("pop4_d0", 32'(bus.data_out[0]), 32'h30);
      chk("pop4_d1", 32'(bus.data_out[1]), 32'h31);
      chk("pop4_d2", 32'(bus.data_out[2]), 32'h60);
      chk("pop4_d3", 32'(bus.data_out[3]), 32'h61);
      chk("pop4_af", 32'(bus.almost_full), 1);
      chk("pop4_in_en", 32'(bus.data_in_enable), 32'hF);
      // Gapped pop: only port 0 leaves.
      bus.pop = 1'b1; bus.data_pop_valid = 4'b1101; tick(); idle();
      chk("gpop_used", 32'(bus.used_count), 3);
      chk("gpop_out_vld", 32'(bus.data_out_valid), 32'h7);
      chk("gpop_d0", 32'(bus.data_out[0]), 32'h31);
      chk("gpop_af", 32'(bus.almost_full), 0);

      // Steady push 3 / pop 3 across several pointer wraps.
      q = '{8'h31, 8'h60, 8'h61};
      v = 8'h80;
      for (int c = 0; c < 12; c++) begin
         chk("wrap_d0", 32'(bus.data_out[0]), 32'(q[0]));
         chk("wrap_used", 32'(bus.used_count), 3);
         set_in(4'b0111, v);
         bus.push = 1'b1; bus.pop = 1'b1; bus.data_pop_valid = 4'b0111;
         tick(); idle();
         for (int k = 0; k < 3; k++) begin
            void'(q.pop_front());
            q.push_back(v + 8'(k));
         end
         v = v + 8'd3;
      end
      chk("wrap_end_d0", 32'(bus.data_out[0]), 32'(q[0]));
      chk("wrap_end_d2", 32'(bus.data_out[2]), 32'(q[2]));
      chk("wrap_end_used", 32'(bus.used_count), 3);

      // Flush beats push/pop.
      set_in(4'b0011, 8'hC0); bus.push = 1'b1; tick(); idle();
      chk("pre_flush_used", 32'(bus.used_count), 5);
      set_in(4'b1111, 8'hE0); bus.flush = 1'b1; bus.push = 1'b1;
      bus.pop = 1'b1; bus.data_pop_valid = 4'b1111; tick(); idle();
      chk("flush_empty", 32'(bus.empty), 1);
      chk("flush_used", 32'(bus.used_count), 0);
      chk("flush_free", 32'(bus.free_count), 8);
      chk("flush_out_vld", 32'(bus.data_out_valid), 0);
      chk("flush_in_en", 32'(bus.data_in_enable), 32'hF);

      // Push+pop at empty: the write lands and appears next cycle.
      set_in(4'b0001, 8'hAA); bus.push = 1'b1; bus.pop = 1'b1; bus.data_pop_valid = 4'b1111;
      tick(); idle();
      chk("empty_pp_used", 32'(bus.used_count), 1);
      chk("empty_pp_d0", 32'(bus.data_out[0]), 32'hAA);
      chk("empty_pp_out_vld", 32'(bus.data_out_valid), 32'h1);

      // Reset beats push/pop.
      set_in(4'b1111, 8'hB0); bus.push = 1'b1; tick(); idle();
      chk("pre_rst_used", 32'(bus.used_count), 5);
      rst = 1'b0;
      set_in(4'b1111, 8'hF0); bus.push = 1'b1; bus.pop = 1'b1; bus.data_pop_valid = 4'b1111;
      tick(); idle();
      rst = 1'b1;
      chk("rst2_empty", 32'(bus.empty), 1);
      chk("rst2_used", 32'(bus.used_count), 0);
      chk("rst2_free", 32'(bus.free_count), 8);
      chk("rst2_out_vld", 32'(bus.data_out_valid), 0);
      chk("rst2_af", 32'(bus.almost_full), 0);
      set_in(4'b0001, 8'hD0); bus.push = 1'b1; tick(); idle();
      chk("post_rst_d0", 32'(bus.data_out[0]), 32'hD0);
      chk("post_rst_used", 32'(bus.used_count), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
